vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 134 +++++++++++++
 tb/tb_vram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: shares one single-port RAM between a scanout engine
// that fetches fixed-length read bursts and a CPU doing single-word
// reads/writes. Simultaneous requests alternate through a last-grant flag,
// so a waiting CPU never sits behind more than one burst.
module vram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BURST  = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_ack,
  output logic [DATA_W-1:0]   vid_rdata,
  output logic                vid_rvalid,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {IDLE, VID, CPU, CPU_WAIT} state_t;

  state_t              state;
  logic                last_vid;
  logic [CNT_W-1:0]    cnt;
  logic                cpu_rd;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                grant_vid;
  logic                grant_cpu;

  // Arbitration in IDLE: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (state == IDLE) begin
      if (vid_req && cpu_req) begin
        grant_cpu = last_vid;
        grant_vid = !last_vid;
      end else begin
        grant_vid = vid_req;
        grant_cpu = cpu_req;
      end
    end
  end

  // RAM read data is only forwarded while the matching qualifier is high; a
  // CPU write leaves the last read value on cpu_rdata.
  assign vid_rdata = vid_rvalid ? mem_rdata : '0;
  assign cpu_rdata = (cpu_ack && cpu_rd) ? mem_rdata : cpu_rdata_q;

  // Main FSM with registered RAM command and handshake outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      last_vid    <= 1'b0;
      cnt         <= '0;
      cpu_rd      <= 1'b0;
      cpu_rdata_q <= '0;
      vid_ack     <= 1'b0;
      vid_rvalid  <= 1'b0;
      cpu_ack     <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
    end else begin
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_rvalid <= (state == VID);
      unique case (state)
        IDLE: begin
          if (grant_vid) begin
            vid_ack  <= 1'b1;
            last_vid <= 1'b1;
            cnt      <= '0;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_be   <= '0;
            mem_addr <= vid_addr;
            state    <= VID;
          end else if (grant_cpu) begin
            last_vid  <= 1'b0;
            cpu_rd    <= !cpu_we;
            mem_en    <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_be    <= cpu_we ? cpu_be : BE_W'(0);
            state     <= CPU;
          end
        end
        VID: begin
          if (cnt == CNT_W'(BURST - 1)) begin
            mem_en <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt      <= cnt + CNT_W'(1);
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        CPU: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          mem_be  <= '0;
          cpu_ack <= 1'b1;
          state   <= CPU_WAIT;
        end
        CPU_WAIT: begin
          if (cpu_rd) begin
            cpu_rdata_q <= mem_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: behavioural single-port RAM with one-cycle
// read latency, scenario tasks with queued expectations.
module tb_vram_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BURST  = 8;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_rvalid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [1:0]        cpu_be;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram [int];

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Free-running clock, 10 ns period.
  always #5 CLK = ~CLK;

  // Unwritten RAM locations hold a fixed address-derived pattern.
  function automatic logic [15:0] ram_read(input logic [15:0] a);
    if (ram.exists(int'(a))) return ram[int'(a)];
    return a ^ 16'h5A5A;
  endfunction

  // RAM model: byte-masked writes, read data one cycle after mem_en.
  always @(posedge CLK) begin
    logic [15:0] v;
    if (mem_en) begin
      if (mem_we) begin
        v = ram_read(mem_addr);
        if (mem_be[0]) v[7:0]  = mem_wdata[7:0];
        if (mem_be[1]) v[15:8] = mem_wdata[15:8];
        ram[int'(mem_addr)] = v;
      end else begin
        mem_rdata <= ram_read(mem_addr);
      end
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic test_reset();
    RST_N = 1'b0; vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rdata, mem_en, mem_we,
         mem_addr, mem_wdata, mem_be} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rdata, mem_en, mem_we,
                mem_addr, mem_wdata, mem_be});
    end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({vid_ack, cpu_ack, mem_en, vid_rvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: got %b required 0000", {vid_ack, cpu_ack, mem_en, vid_rvalid});
    end
  endtask

  task automatic test_vid_burst(input logic [15:0] base, input string name);
    logic [15:0] addr_q[$];
    logic [15:0] data_q[$];
    logic [15:0] exp;
    int waited;
    for (int i = 0; i < BURST; i++) begin
      addr_q.push_back(base + 16'(i));
      data_q.push_back(ram_read(base + 16'(i)));
    end
    vid_req = 1'b1; vid_addr = base;
    waited = 0;
    do begin
      @(negedge CLK);
      waited++;
    end while (vid_ack !== 1'b1 && waited < 20);
    checks++;
    if (vid_ack !== 1'b1) begin
      errors++;
      $display("FAIL %s_ack: got vid_ack=%b required 1 within 20 cycles", name, vid_ack);
      vid_req = 1'b0;
      return;
    end
    vid_req = 1'b0; vid_addr = ~base;
    for (int i = 0; i <= BURST + 1; i++) begin
      if (i > 0) begin
        @(negedge CLK);
        checks++;
        if (vid_ack !== 1'b0) begin
          errors++;
          $display("FAIL %s_ack_pulse: cycle %0d got vid_ack=%b required 0", name, i, vid_ack);
        end
      end
      if (i < BURST) begin
        exp = addr_q.pop_front();
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp) begin
          errors++;
          $display("FAIL %s_issue%0d: got en=%b we=%b addr=%h required en=1 we=0 addr=%h",
                   name, i, mem_en, mem_we, mem_addr, exp);
        end
      end else begin
        checks++;
        if (mem_en !== 1'b0) begin
          errors++;
          $display("FAIL %s_issue_end%0d: got mem_en=%b required 0", name, i, mem_en);
        end
      end
      if (i >= 1 && i <= BURST) begin
        exp = data_q.pop_front();
        checks++;
        if (vid_rvalid !== 1'b1 || vid_rdata !== exp) begin
          errors++;
          $display("FAIL %s_data%0d: got rvalid=%b data=%h required rvalid=1 data=%h",
                   name, i - 1, vid_rvalid, vid_rdata, exp);
        end
      end else begin
        checks++;
        if (vid_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL %s_rvalid_edge%0d: got vid_rvalid=%b required 0", name, i, vid_rvalid);
        end
      end
    end
  endtask

  task automatic test_cpu_access(input logic we, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [1:0] be,
                                 input logic [1:0] exp_be, input logic [15:0] exp_rdata,
                                 input string name);
    logic [15:0] rd_q[$];
    logic [15:0] exp;
    rd_q.push_back(exp_rdata);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    @(negedge CLK);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== we || mem_addr !== addr || mem_be !== exp_be ||
        (we && mem_wdata !== wdata) || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL %s_issue: got en=%b we=%b addr=%h be=%b wdata=%h ack=%b required en=1 we=%b addr=%h be=%b wdata=%h ack=0",
               name, mem_en, mem_we, mem_addr, mem_be, mem_wdata, cpu_ack, we, addr, exp_be, wdata);
    end
    @(negedge CLK);
    exp = rd_q.pop_front();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== exp || mem_en !== 1'b0 || mem_be !== 2'b00) begin
      errors++;
      $display("FAIL %s_ack: got ack=%b rdata=%h en=%b be=%b required ack=1 rdata=%h en=0 be=00",
               name, cpu_ack, cpu_rdata, mem_en, mem_be, exp);
    end
    cpu_req = 1'b0;
    @(negedge CLK);
    checks++;
    if (cpu_ack !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: got ack=%b en=%b required 0 0", name, cpu_ack, mem_en);
    end
  endtask

  task automatic test_cpu_rw();
    test_cpu_access(1'b1, 16'h0020, 16'hBEEF, 2'b11, 2'b11, 16'h0000, "cpu_write");
    test_cpu_access(1'b0, 16'h0020, 16'h0000, 2'b11, 2'b00, 16'hBEEF, "cpu_read");
    test_cpu_access(1'b1, 16'h0021, 16'h1111, 2'b11, 2'b11, 16'hBEEF, "cpu_write_hold");
  endtask

  task automatic test_byte_enable();
    test_cpu_access(1'b0, 16'h0030, 16'h0000, 2'b01, 2'b00, 16'h5A6A, "be_read");
    test_cpu_access(1'b1, 16'h0030, 16'h1234, 2'b01, 2'b01, 16'h5A6A, "be_write");
    test_cpu_access(1'b0, 16'h0030, 16'h0000, 2'b11, 2'b00, 16'h5A34, "be_readback");
  endtask

  task automatic test_contention();
    string order_q[$];
    string got;
    string exp;
    int cyc;
    int n_vid;
    order_q.push_back("V"); order_q.push_back("C"); order_q.push_back("V");
    @(negedge CLK);
    RST_N = 1'b0;
    vid_req = 1'b1; vid_addr = 16'h0400;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020; cpu_be = 2'b11;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    cyc = 0; n_vid = 0;
    while (order_q.size() > 0 && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (vid_ack === 1'b1 && cpu_ack === 1'b1) begin
        checks++; errors++;
        $display("FAIL contention_both_acks: cycle %0d got both acks high required at most one", cyc);
      end
      if (vid_ack === 1'b1 || cpu_ack === 1'b1) begin
        got = (vid_ack === 1'b1) ? "V" : "C";
        exp = order_q.pop_front();
        checks++;
        if (got != exp) begin
          errors++;
          $display("FAIL contention_order: cycle %0d got %s required %s", cyc, got, exp);
        end
        if (got == "V" && n_vid == 0) begin
          checks++;
          if (cyc != 1) begin
            errors++;
            $display("FAIL contention_first_vid: got cycle %0d required 1", cyc);
          end
        end
        if (got == "V") n_vid++;
        if (got == "C") begin
          checks++;
          if (cyc > BURST + 3 || cpu_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL contention_cpu: got cycle %0d rdata %h required cycle<=%0d rdata BEEF",
                     cyc, cpu_rdata, BURST + 3);
          end
          cpu_req = 1'b0;
        end
      end
    end
    checks++;
    if (order_q.size() != 0) begin
      errors++;
      $display("FAIL contention_timeout: got %0d grants outstanding required 0", order_q.size());
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (BURST + 4) @(negedge CLK);
  endtask

  task automatic test_reset_abort();
    int waited;
    vid_req = 1'b1; vid_addr = 16'h0200;
    waited = 0;
    do begin
      @(negedge CLK);
      waited++;
    end while (vid_ack !== 1'b1 && waited < 20);
    vid_req = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0203) begin
      errors++;
      $display("FAIL abort_4th_issue: got en=%b addr=%h required en=1 addr=0203", mem_en, mem_addr);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rdata, mem_en, mem_we,
         mem_addr, mem_wdata, mem_be} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got %h required 0",
               {vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rdata, mem_en, mem_we,
                mem_addr, mem_wdata, mem_be});
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      checks++;
      if ({vid_rvalid, vid_ack, cpu_ack, mem_en} !== 4'b0000) begin
        errors++;
        $display("FAIL abort_quiet%0d: got rvalid/vack/cack/en=%b required 0000", i,
                 {vid_rvalid, vid_ack, cpu_ack, mem_en});
      end
    end
    test_vid_burst(16'h0300, "post_abort");
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] vram_arbiter bench start");
    test_reset();
    test_vid_burst(16'h0100, "burst_0100");
    test_cpu_rw();
    test_byte_enable();
    test_vid_burst(16'hFFFC, "wrap_fffc");
    test_contention();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
